// File: rtl/case_conv_stream_if.sv
// ---------------------------------------------------------------------------
// case_conv_stream_if
//   Groups the input and output stream signals of case_conv_stream.
//   LANES : characters per beat (lane k occupies bits [8k+7:8k]).
//
//   mode        2        conversion mode (00 pass, 01 upper, 10 lower, 11 toggle)
//   in_valid    1        input beat valid
//   in_ready    1        converter can take a beat this cycle
//   in_data     8*LANES  input characters
//   out_valid   1        output beat valid
//   out_ready   1        downstream accepts the output beat
//   out_data    8*LANES  converted characters
//   out_changed LANES    per-lane "character was modified" flags
//
//   master : the side that produces input beats and consumes output beats
//   slave  : the converter itself
// ---------------------------------------------------------------------------
interface case_conv_stream_if #(
  parameter int LANES = 1
);
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_changed;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_changed
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_changed
  );
endinterface

// File: rtl/case_conv_stream.sv
// ---------------------------------------------------------------------------
// case_conv_stream
//   Streaming ASCII case converter. Each accepted beat carries LANES
//   characters; every letter is converted to upper case, lower case or has
//   its case toggled, depending on the mode sampled with the beat. Bytes
//   outside 'A'..'Z' / 'a'..'z' (including anything with bit 7 set) pass
//   through untouched. The result sits in a single output register with a
//   per-lane changed mask, and a saturating counter totals changed characters.
//
//   Parameters
//     LANES   : characters per beat, 1..16
//     COUNT_W : width of conv_count, >= 8
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        stream interface (slave side): mode, in_valid/in_ready/
//                in_data, out_valid/out_ready/out_data/out_changed
//     clr_count  synchronous clear of conv_count, wins over a same-cycle add
//     conv_count saturating total of changed characters
// ---------------------------------------------------------------------------
module case_conv_stream #(
  parameter int LANES   = 1,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  case_conv_stream_if.slave  bus,
  input  logic               clr_count,
  output logic [COUNT_W-1:0] conv_count
);

  localparam int DW = 8 * LANES;
  localparam int PW = $clog2(LANES + 1);

  // Combinational conversion of the beat presented on the input.
  logic [DW-1:0]    conv_data;
  logic [LANES-1:0] conv_mask;

  // Output register and counter.
  logic [DW-1:0]      data_q, data_d;
  logic [LANES-1:0]   changed_q, changed_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               accept;
  logic               transfer;
  logic [PW-1:0]      pop;
  logic [COUNT_W:0]   sum;

  // Per-lane letter detection on all 8 bits. Converting case is only ever a
  // flip of bit 5, so each lane just decides whether to flip it.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] ch;
      logic       is_up;
      logic       is_lo;
      logic       flip;

      assign ch    = bus.in_data[8*gi +: 8];
      assign is_up = (ch >= 8'h41) && (ch <= 8'h5A);
      assign is_lo = (ch >= 8'h61) && (ch <= 8'h7A);

      always_comb begin
        flip = 1'b0;
        case (bus.mode)
          2'b01:   flip = is_lo;
          2'b10:   flip = is_up;
          2'b11:   flip = is_up | is_lo;
          default: flip = 1'b0;
        endcase
      end

      assign conv_mask[gi]          = flip;
      assign conv_data[8*gi +: 8]   = {ch[7:6], ch[5] ^ flip, ch[4:0]};
    end
  endgenerate

  // Number of lanes modified in the incoming beat.
  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + PW'(conv_mask[i]);
    end
  end

  // One extra bit catches the carry so the counter can clamp instead of wrap.
  assign sum = {1'b0, count_q} + (COUNT_W + 1)'(pop);

  // Ready depends only on the register state and out_ready, never on
  // in_valid, so upstream logic cannot form a combinational loop through us.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign transfer     = valid_q && bus.out_ready;

  always_comb begin
    data_d    = data_q;
    changed_d = changed_q;
    valid_d   = valid_q;
    if (accept) begin
      // Covers simultaneous transfer+accept: the new beat replaces the old
      // one and valid stays high for full throughput.
      data_d    = conv_data;
      changed_d = conv_mask;
      valid_d   = 1'b1;
    end else if (transfer) begin
      valid_d   = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (accept) begin
      count_d = sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      changed_q <= '0;
      valid_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      data_q    <= data_d;
      changed_q <= changed_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_changed = changed_q;
  assign conv_count      = count_q;

endmodule

// File: tb/tb_case_conv_stream.sv
// ---------------------------------------------------------------------------
// tb_case_conv_stream
//   Two converters: a 4-lane one with an 8-bit counter (directed cases,
//   backpressure, random scoreboard, counter clear/saturation, mid-stream
//   reset) and a 1-lane one (mode sweep). Inputs are driven and outputs
//   sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_case_conv_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clr4;
  logic        clr1;
  logic [7:0]  cnt4;
  logic [15:0] cnt1;

  case_conv_stream_if #(.LANES(4)) s4 ();
  case_conv_stream_if #(.LANES(1)) s1 ();

  case_conv_stream #(.LANES(4), .COUNT_W(8)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus        (s4),
    .clr_count  (clr4),
    .conv_count (cnt4)
  );

  case_conv_stream #(.LANES(1), .COUNT_W(16)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (s1),
    .clr_count  (clr1),
    .conv_count (cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: case conversion by character arithmetic on the ASCII code.
  function automatic logic [7:0] ref_char(input logic [7:0] c, input logic [1:0] m);
    int v;
    bit up;
    bit lo;
    v  = int'(c);
    up = (v >= 65) && (v <= 90);
    lo = (v >= 97) && (v <= 122);
    case (m)
      2'd1:    return lo ? 8'(v - 32) : c;
      2'd2:    return up ? 8'(v + 32) : c;
      2'd3:    return up ? 8'(v + 32) : (lo ? 8'(v - 32) : c);
      default: return c;
    endcase
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_char(d[8*k +: 8], m);
    return r;
  endfunction

  function automatic logic [3:0] ref_mask(input logic [31:0] d, input logic [1:0] m);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (ref_char(d[8*k +: 8], m) != d[8*k +: 8]);
    return r;
  endfunction

  function automatic int ones4(input logic [3:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 4; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic int sat_add(input int a, input int b, input int maxv);
    return (a + b > maxv) ? maxv : a + b;
  endfunction

  // Random character biased toward letters and the range boundaries.
  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 3))
      0: return 8'($urandom_range(0, 255));
      1: return 8'($urandom_range(65, 90));
      2: return 8'($urandom_range(97, 122));
      default: begin
        case ($urandom_range(0, 7))
          0:       return 8'h40;
          1:       return 8'h5B;
          2:       return 8'h60;
          3:       return 8'h7B;
          4:       return 8'hC1;
          5:       return 8'hE1;
          6:       return 8'h41;
          default: return 8'h7A;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_beat();
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = rand_char();
    return r;
  endfunction

  int exp_cnt4 = 0;
  int exp_cnt1 = 0;

  // One-lane directed conversion: drive at a falling edge, check at the next.
  task automatic run1(input string tag, input logic [7:0] c, input logic [1:0] m,
                      input logic [7:0] exp);
    s1.in_valid  = 1'b1;
    s1.in_data   = c;
    s1.mode      = m;
    s1.out_ready = 1'b1;
    @(negedge clk);
    s1.in_valid = 1'b0;
    exp_cnt1 += (exp != c) ? 1 : 0;
    check_val({tag, "_valid"}, s1.out_valid, 1'b1);
    check_val({tag, "_data"}, s1.out_data, exp);
    check_val({tag, "_chg"}, s1.out_changed, (exp != c));
    check_val({tag, "_cnt"}, cnt1, exp_cnt1);
    $display("lane1 %s: in=0x%02h mode=%0d out=0x%02h changed=%0b count=%0d",
             tag, c, m, s1.out_data, s1.out_changed, cnt1);
  endtask

  logic [31:0] q_data[$];
  logic [3:0]  q_mask[$];

  initial begin
    logic [31:0] beat_a;
    logic [31:0] beat_c;
    logic [31:0] prev_data;
    logic [31:0] got_d;
    logic [3:0]  got_m;
    logic [1:0]  mode_c;
    bit          prev_stall;
    int          sent;
    int          rcvd;

    s4.in_valid = 1'b0; s4.in_data = '0; s4.mode = 2'd0; s4.out_ready = 1'b0;
    s1.in_valid = 1'b0; s1.in_data = '0; s1.mode = 2'd0; s1.out_ready = 1'b0;
    clr4 = 1'b0;
    clr1 = 1'b0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);

    // ---------------- reset state ----------------
    @(negedge clk);
    check_val("rst_out_valid", s4.out_valid, 1'b0);
    check_val("rst_out_data", s4.out_data, 32'h0);
    check_val("rst_out_changed", s4.out_changed, 4'h0);
    check_val("rst_count", cnt4, 8'd0);
    check_val("rst_count_l1", cnt1, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", s4.in_ready, 1'b1);
    check_val("rst_in_ready_l1", s1.in_ready, 1'b1);
    $display("reset: out_valid=%0b in_ready=%0b count=%0d", s4.out_valid, s4.in_ready, cnt4);

    // ---------------- 1-lane mode sweep ----------------
    run1("tog_q",   8'h71, 2'd3, 8'h51);
    run1("low_at",  8'h40, 2'd2, 8'h40);
    run1("low_c1",  8'hC1, 2'd2, 8'hC1);
    run1("pass_A",  8'h41, 2'd0, 8'h41);
    run1("up_z",    8'h7A, 2'd1, 8'h5A);
    run1("low_Z",   8'h5A, 2'd2, 8'h7A);
    run1("tog_A",   8'h41, 2'd3, 8'h61);
    run1("up_brace",8'h7B, 2'd1, 8'h7B);
    run1("tog_bq",  8'h60, 2'd3, 8'h60);
    run1("low_brk", 8'h5B, 2'd2, 8'h5B);
    run1("tog_e1",  8'hE1, 2'd3, 8'hE1);

    // ---------------- "aZ9{" to upper ----------------
    s4.in_valid  = 1'b1;
    s4.in_data   = 32'h7B395A61;
    s4.mode      = 2'd1;
    s4.out_ready = 1'b1;
    @(negedge clk);
    s4.in_valid = 1'b0;
    exp_cnt4 = 1;
    check_val("az_valid", s4.out_valid, 1'b1);
    check_val("az_data", s4.out_data, 32'h7B395A41);
    check_val("az_changed", s4.out_changed, 4'b0001);
    check_val("az_count", cnt4, 8'd1);
    $display("beat aZ9{: out=0x%08h changed=%04b count=%0d", s4.out_data, s4.out_changed, cnt4);
    @(negedge clk);
    check_val("az_drained", s4.out_valid, 1'b0);

    // ---------------- backpressure ----------------
    beat_a = 32'h64636261;   // "abcd"
    s4.out_ready = 1'b0;
    s4.in_valid  = 1'b1;
    s4.in_data   = beat_a;
    s4.mode      = 2'd1;
    exp_cnt4     = sat_add(exp_cnt4, ones4(ref_mask(beat_a, 2'd1)), 255);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", s4.out_valid, 1'b1);
      check_val("bp_data", s4.out_data, ref_beat(beat_a, 2'd1));
      check_val("bp_changed", s4.out_changed, 4'hF);
      check_val("bp_in_ready", s4.in_ready, 1'b0);
      check_val("bp_count", cnt4, exp_cnt4);
      $display("stall cycle %0d: out=0x%08h in_ready=%0b count=%0d",
               i, s4.out_data, s4.in_ready, cnt4);
      s4.in_data = rand_beat();
      s4.mode    = 2'($urandom_range(0, 3));
    end
    beat_c       = rand_beat();
    mode_c       = 2'($urandom_range(0, 3));
    s4.in_data   = beat_c;
    s4.mode      = mode_c;
    s4.out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", s4.in_ready, 1'b1);
    exp_cnt4 = sat_add(exp_cnt4, ones4(ref_mask(beat_c, mode_c)), 255);
    @(negedge clk);
    s4.in_valid = 1'b0;
    check_val("bp_next_valid", s4.out_valid, 1'b1);
    check_val("bp_next_data", s4.out_data, ref_beat(beat_c, mode_c));
    check_val("bp_next_changed", s4.out_changed, ref_mask(beat_c, mode_c));
    check_val("bp_next_count", cnt4, exp_cnt4);
    $display("release: out=0x%08h changed=%04b count=%0d", s4.out_data, s4.out_changed, cnt4);
    @(negedge clk);
    check_val("bp_drained", s4.out_valid, 1'b0);

    // ---------------- random scoreboard, 100 beats ----------------
    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 3000 && rcvd < 100; cyc++) begin
      @(negedge clk);
      check_val("sb_count", cnt4, exp_cnt4);
      if (prev_stall) check_val("sb_stall_stable", s4.out_data, prev_data);
      s4.out_ready = ($urandom_range(0, 2) != 0);
      s4.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      s4.mode      = 2'($urandom_range(0, 3));
      s4.in_data   = rand_beat();
      #1;
      check_val("sb_in_ready", s4.in_ready, !s4.out_valid || s4.out_ready);
      if (s4.out_valid && s4.out_ready) begin
        if (q_data.size() == 0) begin
          check_val("sb_unexpected_beat", 1'b1, 1'b0);
        end else begin
          got_d = q_data.pop_front();
          got_m = q_mask.pop_front();
          check_val("sb_data", s4.out_data, got_d);
          check_val("sb_changed", s4.out_changed, got_m);
          $display("sb beat %0d: out=0x%08h changed=%04b", rcvd, s4.out_data, s4.out_changed);
          rcvd++;
        end
      end
      if (s4.in_valid && s4.in_ready) begin
        q_data.push_back(ref_beat(s4.in_data, s4.mode));
        q_mask.push_back(ref_mask(s4.in_data, s4.mode));
        exp_cnt4 = sat_add(exp_cnt4, ones4(ref_mask(s4.in_data, s4.mode)), 255);
        sent++;
      end
      prev_stall = s4.out_valid && !s4.out_ready;
      prev_data  = s4.out_data;
    end
    check_val("sb_all_beats", rcvd, 100);
    s4.in_valid  = 1'b0;
    s4.out_ready = 1'b1;
    @(negedge clk);
    check_val("sb_final_count", cnt4, exp_cnt4);
    @(negedge clk);
    check_val("sb_drained", s4.out_valid, 1'b0);

    // ---------------- clear colliding with accept ----------------
    clr4        = 1'b1;
    s4.in_valid = 1'b1;
    s4.in_data  = 32'h31636261;   // "abc1"
    s4.mode     = 2'd1;
    @(negedge clk);
    clr4        = 1'b0;
    s4.in_valid = 1'b0;
    exp_cnt4    = 0;
    check_val("clr_count", cnt4, 8'd0);
    check_val("clr_valid", s4.out_valid, 1'b1);
    check_val("clr_data", s4.out_data, 32'h31434241);
    check_val("clr_changed", s4.out_changed, 4'b0111);
    $display("clear+accept: out=0x%08h changed=%04b count=%0d", s4.out_data, s4.out_changed, cnt4);

    // ---------------- saturation ----------------
    s4.in_valid = 1'b1;
    s4.in_data  = 32'h64636261;
    s4.mode     = 2'd1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      exp_cnt4 = sat_add(exp_cnt4, 4, 255);
      check_val("sat_count", cnt4, exp_cnt4);
      $display("sat beat %0d: count=%0d", i, cnt4);
    end
    s4.in_valid = 1'b0;
    @(negedge clk);
    check_val("sat_hold", cnt4, 8'd255);
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    exp_cnt4 = 0;
    check_val("clr_alone", cnt4, 8'd0);

    // ---------------- reset mid-stream ----------------
    s4.out_ready = 1'b0;
    s4.in_valid  = 1'b1;
    s4.in_data   = 32'h7A797877;   // "wxyz"
    s4.mode      = 2'd3;
    @(negedge clk);
    s4.in_valid = 1'b0;
    check_val("mid_valid_before", s4.out_valid, 1'b1);
    check_val("mid_count_before", cnt4, 8'd4);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_valid_after", s4.out_valid, 1'b0);
    check_val("mid_count_after", cnt4, 8'd0);
    check_val("mid_in_ready", s4.in_ready, 1'b1);
    check_val("mid_data_after", s4.out_data, 32'h0);
    $display("mid-stream reset: out_valid=%0b in_ready=%0b count=%0d", s4.out_valid, s4.in_ready, cnt4);
    rst = 1'b0;
    s4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("mid_no_stale", s4.out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/case_conv_stream.md
# case_conv_stream

Streaming ASCII case converter for the text path. It takes LANES characters per beat over a valid/ready handshake and converts each letter to upper case, to lower case, or toggles its case, selected per beat. Results leave through one registered output stage. Unlike the fixed combinational to-upper stage, it range-checks letters so non-letters always pass unchanged, reports which lanes were modified, and keeps a saturating count of converted characters.

## Interface
- LANES, 1: characters per beat; legal range 1–16.
- COUNT_W, 16: width of the converted-character counter; minimum 8.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- mode  input  2  conversion mode, sampled with each accepted beat: 00 pass, 01 upper, 10 lower, 11 toggle.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  8*LANES  input characters; lane k occupies bits [8k+7:8k].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the output beat.
- out_data  output  8*LANES  converted characters, same lane order as in_data.
- out_changed  output  LANES  bit k = 1 when lane k of out_data differs from its input.
- conv_count  output  COUNT_W  running total of changed characters, saturating.
- clr_count  input  1  synchronous clear of conv_count.

## Operation
- Letter detection, per lane, on the full 8 bits:
  - Upper-case letter: 0x41–0x5A.
  - Lower-case letter: 0x61–0x7A.
  - Any other byte, including bit7 = 1, is a non-letter and passes unchanged in every mode.
- Conversion per lane. Only bit 5 ever changes.
  - pass: unchanged.
  - upper: lower-case letters have bit 5 cleared; everything else unchanged.
  - lower: upper-case letters have bit 5 set; everything else unchanged.
  - toggle: every letter has bit 5 inverted.
- out_changed[k] is 1 exactly when lane k was modified.
- Output stage: a single register holding data, the changed mask and a valid bit.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready, with no path from in_valid.
  - Accept: in_valid && in_ready. On accept, the register loads the converted beat and out_valid = 1.
  - Output transfer: out_valid && out_ready. On transfer with no accept in the same cycle, out_valid = 0.
  - Transfer and accept in the same cycle: the register loads the new beat and out_valid stays 1 (full throughput).
  - While out_valid && !out_ready: out_data, out_changed and out_valid hold stable, and in_ready = 0.
- Counter, updated on accept:
  - conv_count += popcount(out_changed of the accepted beat).
  - Saturates at 2^COUNT_W−1 and never wraps.
  - clr_count has priority. When clr_count and an accept occur in the same cycle, conv_count = 0 and that beat's contribution is discarded.
  - clr_count does not affect the data path.
- Reset:
  - out_valid = 0, out_data = 0, out_changed = 0, conv_count = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset asserted mid-stream discards the held beat; no partial output is produced.

## Timing
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- mode is sampled only on accept. Changing mode while the output is stalled does not alter the held beat.
- in_data and mode are don't-care when in_valid = 0.
- conv_count is registered and updates on the edge of the accept.

## Test plan
- Reset, then LANES = 4, mode = 01, in_data = "aZ9{" (0x7B395A61, lane 0 = 'a') with out_ready = 1:
  - next cycle out_data = 0x7B395A41, out_changed = 0001, conv_count = 1.
- Mode sweep on LANES = 1:
  - toggle of 'q' (0x71) → 0x51.
  - lower of '@' (0x40) → 0x40, out_changed = 0.
  - lower of 0xC1 → 0xC1, out_changed = 0.
  - pass of 'A' → 'A', out_changed = 0.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1:
  - exactly one beat is accepted, then in_ready = 0.
  - out_data is stable throughout.
  - on releasing out_ready, the next beat follows with no loss or duplication (scoreboard 100 random beats with random out_ready).
- Saturation: COUNT_W = 8, stream 70 beats of LANES = 4 all-letter data in upper-from-lower mode:
  - conv_count stops at 255 and stays there.
- Counter clear collision: clr_count = 1 in the same cycle as accepting a beat with 3 changed lanes:
  - conv_count = 0, and the beat is still output.
- Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0:
  - next cycle out_valid = 0, conv_count = 0, in_ready = 1.
  - the stalled beat is never presented.
